// File: rtl/decode_stage_pkg.sv
// Shared types and constants for the RV32I decode stage: opcodes, control encodings,
// the D->E pipeline register layout, and decode helpers.
package decode_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SRL   = 4'd7,
    ALU_SRA   = 4'd8,
    ALU_PASSB = 4'd9
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        alu_src;
    result_src_e result_src;
    alu_ctrl_e   alu_ctrl;
  } ctrl_t;

  typedef struct packed {
    ctrl_t             ctrl;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc_plus4;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } de_reg_t;

  // Sign-extended immediate for each instruction format.
  function automatic logic [XLEN-1:0] imm_extend(input logic [XLEN-1:0] i, input imm_src_e src);
    logic [XLEN-1:0] r;
    r = '0;
    case (src)
      IMM_I:   r = {{20{i[31]}}, i[31:20]};
      IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      IMM_U:   r = {i[31:12], 12'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

  // ALU operation from funct3/funct7[5]; SUB only exists in register-register form.
  function automatic alu_ctrl_e alu_decode(input logic [2:0] f3, input logic f7b5, input logic is_r);
    alu_ctrl_e a;
    a = ALU_ADD;
    case (f3)
      3'b000:  a = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  a = ALU_SLL;
      3'b010:  a = ALU_SLT;
      3'b100:  a = ALU_XOR;
      3'b101:  a = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  a = ALU_OR;
      3'b111:  a = ALU_AND;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Decode-stage bus: fetch inputs, writeback/forwarding inputs, fetch redirect and D->E outputs.
interface decode_stage_if;
  import decode_stage_pkg::*;

  logic [XLEN-1:0]   InstrD;
  logic [XLEN-1:0]   PCPlus4D;
  logic              RegWriteW;
  logic [REG_AW-1:0] RdW;
  logic [XLEN-1:0]   ResultW;
  logic [XLEN-1:0]   ALUResultM;
  logic              ForwardAD;
  logic              ForwardBD;
  logic              FlushE;

  logic [XLEN-1:0]   PCBranchD;
  logic              PCSrcD;
  logic              BranchD;
  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;
  logic              IllegalD;

  logic              RegWriteE;
  logic              MemWriteE;
  logic              ALUSrcE;
  logic [1:0]        ResultSrcE;
  logic [3:0]        ALUControlE;
  logic [XLEN-1:0]   RD1E;
  logic [XLEN-1:0]   RD2E;
  logic [XLEN-1:0]   ImmExtE;
  logic [XLEN-1:0]   PCPlus4E;
  logic [REG_AW-1:0] Rs1E;
  logic [REG_AW-1:0] Rs2E;
  logic [REG_AW-1:0] RdE;

  modport master (
    output InstrD, PCPlus4D, RegWriteW, RdW, ResultW, ALUResultM, ForwardAD, ForwardBD, FlushE,
    input  PCBranchD, PCSrcD, BranchD, Rs1D, Rs2D, IllegalD,
    input  RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, ALUControlE,
    input  RD1E, RD2E, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE
  );

  modport slave (
    input  InstrD, PCPlus4D, RegWriteW, RdW, ResultW, ALUResultM, ForwardAD, ForwardBD, FlushE,
    output PCBranchD, PCSrcD, BranchD, Rs1D, Rs2D, IllegalD,
    output RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, ALUControlE,
    output RD1E, RD2E, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE
  );
endinterface

// File: rtl/decode_stage_regfile.sv
// 2-read/1-write register file; x0 reads zero, same-cycle writes bypass to the read ports.
module decode_stage_regfile
  import decode_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1_c,
  output logic [XLEN-1:0]   rdata2_c
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;

  assign wr_en = we && (waddr != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  // Write-through so a writeback and a dependent decode can share a cycle.
  always_comb begin
    rdata1_c = '0;
    rdata2_c = '0;
    if (raddr1 != '0) rdata1_c = (wr_en && waddr == raddr1) ? wdata : regs[raddr1];
    if (raddr2 != '0) rdata2_c = (wr_en && waddr == raddr2) ? wdata : regs[raddr2];
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: control decode, immediates, early branch/jump resolution and the D->E register.
module decode_stage
  import decode_stage_pkg::*;
(
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave bus
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              funct7_b5;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]   rd1, rd2, imm_ext, opa, opb;
  logic [XLEN-1:0]   pc_d, br_base, br_sum;
  ctrl_t             ctrl;
  imm_src_e          imm_src;
  logic              is_beq, is_bne, is_jal, is_jalr, illegal;
  de_reg_t           e_d, e_q;

  assign opcode    = bus.InstrD[6:0];
  assign funct3    = bus.InstrD[14:12];
  assign funct7_b5 = bus.InstrD[30];
  assign rd        = bus.InstrD[11:7];
  assign rs1       = bus.InstrD[19:15];
  assign rs2       = bus.InstrD[24:20];

  decode_stage_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (bus.RegWriteW),
    .waddr    (bus.RdW),
    .wdata    (bus.ResultW),
    .raddr1   (rs1),
    .raddr2   (rs2),
    .rdata1_c (rd1),
    .rdata2_c (rd2)
  );

  // Main control decode; unsupported opcodes leave every control at zero.
  always_comb begin
    ctrl    = '0;
    imm_src = IMM_I;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_jal  = 1'b0;
    is_jalr = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl  = alu_decode(funct3, funct7_b5, 1'b1);
      end
      OP_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = alu_decode(funct3, funct7_b5, 1'b0);
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm_src        = IMM_S;
      end
      OP_BR: begin
        ctrl.alu_ctrl = ALU_SUB;
        imm_src       = IMM_B;
        is_beq        = (funct3 == 3'b000);
        is_bne        = (funct3 == 3'b001);
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        imm_src         = IMM_J;
        is_jal          = 1'b1;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_PC4;
        is_jalr         = 1'b1;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_PASSB;
        imm_src        = IMM_U;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign imm_ext = imm_extend(bus.InstrD, imm_src);

  // Early redirect: compare operands may come from M via the hazard unit.
  assign opa     = bus.ForwardAD ? bus.ALUResultM : rd1;
  assign opb     = bus.ForwardBD ? bus.ALUResultM : rd2;
  assign pc_d    = bus.PCPlus4D - XLEN'(4);
  assign br_base = is_jalr ? opa : pc_d;
  assign br_sum  = br_base + imm_ext;

  assign bus.PCBranchD = is_jalr ? {br_sum[XLEN-1:1], 1'b0} : br_sum;
  assign bus.PCSrcD    = (is_beq && (opa == opb)) || (is_bne && (opa != opb)) || is_jal || is_jalr;
  assign bus.BranchD   = is_beq || is_bne;
  assign bus.Rs1D      = rs1;
  assign bus.Rs2D      = rs2;
  assign bus.IllegalD  = illegal;

  always_comb begin
    e_d          = '0;
    e_d.ctrl     = ctrl;
    e_d.rd1      = rd1;
    e_d.rd2      = rd2;
    e_d.imm      = imm_ext;
    e_d.pc_plus4 = bus.PCPlus4D;
    e_d.rs1      = rs1;
    e_d.rs2      = rs2;
    e_d.rd       = rd;
  end

  // D->E register; a flush loads an all-zero bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= '0;
    end else if (bus.FlushE) begin
      e_q <= '0;
    end else begin
      e_q <= e_d;
    end
  end

  assign bus.RegWriteE   = e_q.ctrl.reg_write;
  assign bus.MemWriteE   = e_q.ctrl.mem_write;
  assign bus.ALUSrcE     = e_q.ctrl.alu_src;
  assign bus.ResultSrcE  = e_q.ctrl.result_src;
  assign bus.ALUControlE = e_q.ctrl.alu_ctrl;
  assign bus.RD1E        = e_q.rd1;
  assign bus.RD2E        = e_q.rd2;
  assign bus.ImmExtE     = e_q.imm;
  assign bus.PCPlus4E    = e_q.pc_plus4;
  assign bus.Rs1E        = e_q.rs1;
  assign bus.Rs2E        = e_q.rs2;
  assign bus.RdE         = e_q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table with an E-stage scoreboard plus
// hand-written reset, write-through, x0, flush and branch sequences.
module tb_decode_stage;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  decode_stage_if bus ();

  decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        fa;
    logic        fb;
    logic [31:0] alum;
    logic        flush;
    logic        pcsrc;
    logic        branch;
    logic [31:0] pcbr;
    logic        illegal;
    logic        rw;
    logic        mw;
    logic        asrc;
    logic [1:0]  rsrc;
    logic [3:0]  actl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic        imm_chk;
    logic [4:0]  rd;
  } vec_t;

  typedef struct {
    int          idx;
    logic        rw;
    logic        mw;
    logic        asrc;
    logic [1:0]  rsrc;
    logic [3:0]  actl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic        imm_chk;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } e_exp_t;

  vec_t   vt[$];
  e_exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc4, input logic fa,
                       input logic fb, input logic [31:0] alum, input logic flush,
                       input logic wbe, input logic [4:0] wrd, input logic [31:0] wres);
    bus.InstrD     = instr;
    bus.PCPlus4D   = pc4;
    bus.ForwardAD  = fa;
    bus.ForwardBD  = fb;
    bus.ALUResultM = alum;
    bus.FlushE     = flush;
    bus.RegWriteW  = wbe;
    bus.RdW        = wrd;
    bus.ResultW    = wres;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    @(negedge clk);
    drive(32'h0000_0013, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, r, d);
    @(posedge clk);
    #1;
    bus.RegWriteW = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int i, input vec_t v);
    e_exp_t e;
    @(negedge clk);
    drive(v.instr, v.pc4, v.fa, v.fb, v.alum, v.flush, 1'b0, 5'd0, 32'h0);
    #1;
    chk($sformatf("v%0d PCSrcD", i),   32'(bus.PCSrcD),   32'(v.pcsrc));
    chk($sformatf("v%0d BranchD", i),  32'(bus.BranchD),  32'(v.branch));
    chk($sformatf("v%0d IllegalD", i), 32'(bus.IllegalD), 32'(v.illegal));
    if (v.pcsrc) chk($sformatf("v%0d PCBranchD", i), bus.PCBranchD, v.pcbr);
    e.idx = i;        e.rw = v.rw;     e.mw = v.mw;     e.asrc = v.asrc;
    e.rsrc = v.rsrc;  e.actl = v.actl; e.rd1 = v.rd1;   e.rd2 = v.rd2;
    e.imm = v.imm;    e.imm_chk = v.imm_chk;
    e.pc4 = v.flush ? 32'h0 : v.pc4;
    e.rd = v.rd;
    sb.push_back(e);
    tick();
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL v%0d scoreboard: got empty queue expected one entry", i);
    end else begin
      e = sb.pop_front();
      chk($sformatf("v%0d RegWriteE", e.idx),   32'(bus.RegWriteE),   32'(e.rw));
      chk($sformatf("v%0d MemWriteE", e.idx),   32'(bus.MemWriteE),   32'(e.mw));
      chk($sformatf("v%0d ALUSrcE", e.idx),     32'(bus.ALUSrcE),     32'(e.asrc));
      chk($sformatf("v%0d ResultSrcE", e.idx),  32'(bus.ResultSrcE),  32'(e.rsrc));
      chk($sformatf("v%0d ALUControlE", e.idx), 32'(bus.ALUControlE), 32'(e.actl));
      chk($sformatf("v%0d RD1E", e.idx),        bus.RD1E,             e.rd1);
      chk($sformatf("v%0d RD2E", e.idx),        bus.RD2E,             e.rd2);
      if (e.imm_chk) chk($sformatf("v%0d ImmExtE", e.idx), bus.ImmExtE, e.imm);
      chk($sformatf("v%0d PCPlus4E", e.idx),    bus.PCPlus4E,         e.pc4);
      chk($sformatf("v%0d RdE", e.idx),         32'(bus.RdE),         32'(e.rd));
    end
  endtask

  task automatic chk_e_zero(input string tag);
    chk({tag, " RegWriteE"},   32'(bus.RegWriteE),   32'h0);
    chk({tag, " MemWriteE"},   32'(bus.MemWriteE),   32'h0);
    chk({tag, " ResultSrcE"},  32'(bus.ResultSrcE),  32'h0);
    chk({tag, " ALUControlE"}, 32'(bus.ALUControlE), 32'h0);
    chk({tag, " RD1E"},        bus.RD1E,             32'h0);
    chk({tag, " ImmExtE"},     bus.ImmExtE,          32'h0);
    chk({tag, " PCPlus4E"},    bus.PCPlus4E,         32'h0);
    chk({tag, " RdE"},         32'(bus.RdE),         32'h0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    drive(32'h0000_0013, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);

    // Regs during the table: x1=3, x2=3, x3=0x201, x4=0x10, others 0.
    //           instr          pc4        fa    fb    alum        fl    pcsrc br    pcbr          ill   rw    mw    asrc  rsrc  actl  rd1           rd2           imm           ichk  rd
    vt.push_back('{32'h402083B3, 32'h100, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd1, 32'h3,        32'h3,        32'h0,        1'b0, 5'd7});
    vt.push_back('{32'h0040F5B3, 32'h104, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd2, 32'h3,        32'h10,       32'h0,        1'b0, 5'd11});
    vt.push_back('{32'hFFF20413, 32'h108, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 4'd0, 32'h10,       32'h0,        32'hFFFFFFFF, 1'b1, 5'd8});
    vt.push_back('{32'h40325493, 32'h10C, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 4'd8, 32'h10,       32'h201,      32'h403,      1'b1, 5'd9});
    vt.push_back('{32'hFFC12383, 32'h110, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 4'd0, 32'h3,        32'h0,        32'hFFFFFFFC, 1'b1, 5'd7});
    vt.push_back('{32'h0041A423, 32'h114, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 4'd0, 32'h201,      32'h10,       32'h8,        1'b1, 5'd8});
    vt.push_back('{32'hFE208CE3, 32'h104, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b1, 32'hF8,       1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd1, 32'h3,        32'h3,        32'hFFFFFFF8, 1'b1, 5'd25});
    vt.push_back('{32'hFE209CE3, 32'h104, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd1, 32'h3,        32'h3,        32'hFFFFFFF8, 1'b1, 5'd25});
    vt.push_back('{32'hFE209CE3, 32'h204, 1'b0, 1'b1, 32'h5,     1'b0, 1'b1, 1'b1, 32'h1F8,      1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd1, 32'h3,        32'h3,        32'hFFFFFFF8, 1'b1, 5'd25});
    vt.push_back('{32'h100000EF, 32'h204, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 32'h300,      1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 4'd0, 32'h0,        32'h0,        32'h100,      1'b1, 5'd1});
    vt.push_back('{32'h004180E7, 32'h300, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 32'h204,      1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 4'd0, 32'h201,      32'h10,       32'h4,        1'b1, 5'd1});
    vt.push_back('{32'h004180E7, 32'h300, 1'b1, 1'b0, 32'h301,   1'b0, 1'b1, 1'b0, 32'h304,      1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 4'd0, 32'h201,      32'h10,       32'h4,        1'b1, 5'd1});
    vt.push_back('{32'h12345537, 32'h400, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 4'd9, 32'h0,        32'h201,      32'h12345000, 1'b1, 5'd10});
    vt.push_back('{32'h00000000, 32'h404, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0});
    vt.push_back('{32'hFFC12383, 32'h408, 1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 32'h0,        32'h0,        32'h0,        1'b1, 5'd0});

    // Reset state with the clock running.
    #12;
    chk_e_zero("rst");
    @(negedge clk);
    reset = 1'b1;

    wb(5'd1, 32'h3);
    wb(5'd2, 32'h3);
    wb(5'd3, 32'h201);
    wb(5'd4, 32'h10);

    // Source fields are passed straight through to the hazard unit.
    @(negedge clk);
    drive(32'h0041A423, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("Rs1D", 32'(bus.Rs1D), 32'd3);
    chk("Rs2D", 32'(bus.Rs2D), 32'd4);

    foreach (vt[i]) apply(i, vt[i]);

    // Asynchronous reset mid-run clears E and the regfile without a clock edge.
    wb(5'd5, 32'h55);
    @(negedge clk);
    drive(32'h100000EF, 32'h204, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("pre-rst PCPlus4E", bus.PCPlus4E, 32'h204);
    #2;
    reset = 1'b0;
    #1;
    chk_e_zero("async-rst");
    @(negedge clk);
    reset = 1'b1;
    drive(32'h00028333, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("x5 after rst RD1E", bus.RD1E, 32'h0);

    // Writeback and dependent read in the same cycle.
    @(negedge clk);
    drive(32'h00028333, 32'h14, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    chk("wt RD1E", bus.RD1E, 32'hDEAD_BEEF);
    chk("wt RdE", 32'(bus.RdE), 32'd6);

    // Writes to x0 are discarded, including the bypass path.
    @(negedge clk);
    drive(32'h00000333, 32'h18, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 5'd0, 32'h7);
    tick();
    chk("x0 bypass RD1E", bus.RD1E, 32'h0);
    @(negedge clk);
    drive(32'h00000333, 32'h1C, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("x0 stored RD1E", bus.RD1E, 32'h0);

    // beq with unequal operands falls through.
    wb(5'd1, 32'h3);
    wb(5'd2, 32'h4);
    @(negedge clk);
    drive(32'hFE208CE3, 32'h104, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("beq ne PCSrcD", 32'(bus.PCSrcD), 32'h0);
    chk("beq ne BranchD", 32'(bus.BranchD), 32'h1);

    // Flush and writeback together: bubble in E, but the write lands.
    @(negedge clk);
    drive(32'h00060333, 32'h20, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 5'd12, 32'h77);
    tick();
    chk("flush+wb RegWriteE", 32'(bus.RegWriteE), 32'h0);
    chk("flush+wb RdE", 32'(bus.RdE), 32'h0);
    chk("flush+wb RD1E", bus.RD1E, 32'h0);
    @(negedge clk);
    drive(32'h00060333, 32'h24, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("after flush x12 RD1E", bus.RD1E, 32'h77);
    chk("after flush RdE", 32'(bus.RdE), 32'd6);
    chk("after flush Rs1E", 32'(bus.Rs1E), 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
